idu_pipe: RTL and testbench

IDU_PIPE -- requirements
Module: idu_pipe

---
 rtl/idu_pipe.sv | 349 ++++++++++++++++++++++++++++++++++
 tb/tb_idu_pipe.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/idu_pipe.sv
`default_nettype none
// ============================================================================
// Module   : idu_pipe
// Purpose  : RV32I + Zicsr (+ optional M) instruction decode stage. Each
//            accepted instruction is decoded combinationally and the decoded
//            entry is written into a small circular queue. The head entry is
//            presented one cycle after the push.
// Ports    : clk, rst            - clock, synchronous active-high reset
//            flush               - drop every queued entry and same-cycle input
//            in_valid/in_ready   - fetch handshake; in_inst, in_pc payload
//            out_valid/out_ready - downstream handshake on the head entry
//            out_pc, out_rd, out_rs1, out_rs2, out_imm, out_ctrl - head entry
//            out_count           - number of queued entries
// Revision : 1.0 - initial release
// ============================================================================
module idu_pipe #(
    parameter int XLEN   = 32,
    parameter int QDEPTH = 2,
    parameter int EN_M   = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [31:0]               in_inst,
    input  logic [XLEN-1:0]           in_pc,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [XLEN-1:0]           out_pc,
    output logic [4:0]                out_rd,
    output logic [4:0]                out_rs1,
    output logic [4:0]                out_rs2,
    output logic [XLEN-1:0]           out_imm,
    output logic [37:0]               out_ctrl,
    output logic [$clog2(QDEPTH):0]   out_count
);

    localparam int c_PW = $clog2(QDEPTH);
    localparam int c_CW = c_PW + 1;
    localparam int c_EW = 2 * XLEN + 15 + 38;
    localparam logic [c_CW-1:0] c_FULL = c_CW'(QDEPTH);

    // Instruction type codes
    localparam logic [2:0] c_IT_I = 3'd0, c_IT_S = 3'd1, c_IT_R = 3'd2,
                           c_IT_U = 3'd3, c_IT_J = 3'd4, c_IT_B = 3'd5,
                           c_IT_N = 3'd6;
    // Memory access size codes
    localparam logic [2:0] c_MR_B = 3'd0, c_MR_H = 3'd1, c_MR_W = 3'd2,
                           c_MR_BU = 3'd3, c_MR_HU = 3'd4;
    // Compare codes
    localparam logic [2:0] c_CMP_EQ = 3'd0, c_CMP_NE = 3'd1, c_CMP_LT = 3'd2,
                           c_CMP_GE = 3'd3, c_CMP_LTU = 3'd4, c_CMP_GEU = 3'd5;
    // Writeback source codes
    localparam logic [2:0] c_RD_ALU = 3'd0, c_RD_MEM = 3'd1, c_RD_SNPC = 3'd2,
                           c_RD_CMP = 3'd3, c_RD_CSR = 3'd4, c_RD_NONE = 3'd5;
    // Operand source codes
    localparam logic [1:0] c_S1_RS1 = 2'd0, c_S1_PC = 2'd1, c_S1_ZERO = 2'd2;
    localparam logic [1:0] c_S2_RS2 = 2'd0, c_S2_IMM = 2'd1, c_S2_CSR = 2'd2,
                           c_S2_ZERO = 2'd3;
    // ALU operation codes (M-extension ops are 8 + funct3)
    localparam logic [3:0] c_ALU_ADD = 4'd0, c_ALU_SUB = 4'd1, c_ALU_SRA = 4'd2,
                           c_ALU_AND = 4'd3, c_ALU_OR = 4'd4, c_ALU_XOR = 4'd5,
                           c_ALU_SLL = 4'd6, c_ALU_SRL = 4'd7;

    localparam logic [31:0] c_ECALL  = 32'h0000_0073;
    localparam logic [31:0] c_EBREAK = 32'h0010_0073;
    localparam logic [31:0] c_MRET   = 32'h3020_0073;

    // ------------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------------
    logic [6:0] w_opc;
    logic [2:0] w_f3;
    logic [6:0] w_f7;
    assign w_opc = in_inst[6:0];
    assign w_f3  = in_inst[14:12];
    assign w_f7  = in_inst[31:25];

    logic       w_mvalid, w_mwen, w_branch, w_jump, w_jalr;
    logic       w_ecall, w_mret, w_wcsr, w_ebreak, w_ill;
    logic [7:0] w_mwmask;
    logic [2:0] w_mrtype, w_cmp, w_rdsrc, w_itype;
    logic [3:0] w_aluop;
    logic [1:0] w_src1, w_src2;

    always_comb begin
        w_mvalid = 1'b0;
        w_mwen   = 1'b0;
        w_mwmask = 8'h00;
        w_mrtype = c_MR_B;
        w_cmp    = c_CMP_EQ;
        w_branch = 1'b0;
        w_jump   = 1'b0;
        w_jalr   = 1'b0;
        w_aluop  = c_ALU_ADD;
        w_rdsrc  = c_RD_ALU;
        w_src1   = c_S1_RS1;
        w_src2   = c_S2_RS2;
        w_itype  = c_IT_N;
        w_ecall  = 1'b0;
        w_mret   = 1'b0;
        w_wcsr   = 1'b0;
        w_ebreak = 1'b0;
        w_ill    = 1'b0;

        case (w_opc)
            7'b0110111: begin // lui
                w_itype = c_IT_U;
                w_src1  = c_S1_ZERO;
                w_src2  = c_S2_IMM;
            end
            7'b0010111: begin // auipc
                w_itype = c_IT_U;
                w_src1  = c_S1_PC;
                w_src2  = c_S2_IMM;
            end
            7'b1101111: begin // jal: ALU forms the target, rd gets pc+4
                w_itype = c_IT_J;
                w_jump  = 1'b1;
                w_src1  = c_S1_PC;
                w_src2  = c_S2_IMM;
                w_rdsrc = c_RD_SNPC;
            end
            7'b1100111: begin // jalr
                w_itype = c_IT_I;
                w_jump  = 1'b1;
                w_jalr  = 1'b1;
                w_src2  = c_S2_IMM;
                w_rdsrc = c_RD_SNPC;
                if (w_f3 != 3'b000) w_ill = 1'b1;
            end
            7'b1100011: begin // branches compare via subtraction
                w_itype  = c_IT_B;
                w_branch = 1'b1;
                w_aluop  = c_ALU_SUB;
                w_rdsrc  = c_RD_NONE;
                case (w_f3)
                    3'b000:  w_cmp = c_CMP_EQ;
                    3'b001:  w_cmp = c_CMP_NE;
                    3'b100:  w_cmp = c_CMP_LT;
                    3'b101:  w_cmp = c_CMP_GE;
                    3'b110:  w_cmp = c_CMP_LTU;
                    3'b111:  w_cmp = c_CMP_GEU;
                    default: w_ill = 1'b1;
                endcase
            end
            7'b0000011: begin // loads
                w_itype  = c_IT_I;
                w_mvalid = 1'b1;
                w_src2   = c_S2_IMM;
                w_rdsrc  = c_RD_MEM;
                case (w_f3)
                    3'b000:  w_mrtype = c_MR_B;
                    3'b001:  w_mrtype = c_MR_H;
                    3'b010:  w_mrtype = c_MR_W;
                    3'b100:  w_mrtype = c_MR_BU;
                    3'b101:  w_mrtype = c_MR_HU;
                    default: w_ill = 1'b1;
                endcase
            end
            7'b0100011: begin // stores
                w_itype  = c_IT_S;
                w_mvalid = 1'b1;
                w_mwen   = 1'b1;
                w_src2   = c_S2_IMM;
                w_rdsrc  = c_RD_NONE;
                case (w_f3)
                    3'b000:  begin w_mrtype = c_MR_B; w_mwmask = 8'h01; end
                    3'b001:  begin w_mrtype = c_MR_H; w_mwmask = 8'h03; end
                    3'b010:  begin w_mrtype = c_MR_W; w_mwmask = 8'h0F; end
                    default: w_ill = 1'b1;
                endcase
            end
            7'b0010011: begin // op-imm
                w_itype = c_IT_I;
                w_src2  = c_S2_IMM;
                case (w_f3)
                    3'b000: w_aluop = c_ALU_ADD;
                    3'b010: begin w_aluop = c_ALU_SUB; w_cmp = c_CMP_LT;  w_rdsrc = c_RD_CMP; end
                    3'b011: begin w_aluop = c_ALU_SUB; w_cmp = c_CMP_LTU; w_rdsrc = c_RD_CMP; end
                    3'b100: w_aluop = c_ALU_XOR;
                    3'b110: w_aluop = c_ALU_OR;
                    3'b111: w_aluop = c_ALU_AND;
                    3'b001: begin
                        w_aluop = c_ALU_SLL;
                        if (w_f7 != 7'b0000000) w_ill = 1'b1;
                    end
                    default: begin // 3'b101: srli / srai
                        if (w_f7 == 7'b0000000)      w_aluop = c_ALU_SRL;
                        else if (w_f7 == 7'b0100000) w_aluop = c_ALU_SRA;
                        else                         w_ill   = 1'b1;
                    end
                endcase
            end
            7'b0110011: begin // register-register
                w_itype = c_IT_R;
                if (w_f7 == 7'b0000000) begin
                    case (w_f3)
                        3'b000:  w_aluop = c_ALU_ADD;
                        3'b001:  w_aluop = c_ALU_SLL;
                        3'b010:  begin w_aluop = c_ALU_SUB; w_cmp = c_CMP_LT;  w_rdsrc = c_RD_CMP; end
                        3'b011:  begin w_aluop = c_ALU_SUB; w_cmp = c_CMP_LTU; w_rdsrc = c_RD_CMP; end
                        3'b100:  w_aluop = c_ALU_XOR;
                        3'b101:  w_aluop = c_ALU_SRL;
                        3'b110:  w_aluop = c_ALU_OR;
                        default: w_aluop = c_ALU_AND;
                    endcase
                end else if (w_f7 == 7'b0100000) begin
                    if (w_f3 == 3'b000)      w_aluop = c_ALU_SUB;
                    else if (w_f3 == 3'b101) w_aluop = c_ALU_SRA;
                    else                     w_ill   = 1'b1;
                end else if (w_f7 == 7'b0000001 && EN_M != 0) begin
                    w_aluop = {1'b1, w_f3}; // mul..remu map onto 8..15
                end else begin
                    w_ill = 1'b1;
                end
            end
            7'b0001111: begin // fence: no architectural effect here
                w_rdsrc = c_RD_NONE;
                if (w_f3 != 3'b000) w_ill = 1'b1;
            end
            7'b1110011: begin
                case (w_f3)
                    3'b000: begin
                        w_rdsrc = c_RD_NONE;
                        if (in_inst == c_ECALL)       begin w_ecall  = 1'b1; w_wcsr = 1'b1; end
                        else if (in_inst == c_EBREAK) w_ebreak = 1'b1;
                        else if (in_inst == c_MRET)   w_mret   = 1'b1;
                        else                          w_ill    = 1'b1;
                    end
                    // CSR new value is computed as rs1 | operand2: csrrw ORs
                    // with zero, csrrs ORs with the old CSR value. The clear
                    // and immediate forms have no datapath encoding.
                    3'b001: begin
                        w_itype = c_IT_I;
                        w_aluop = c_ALU_OR;
                        w_src2  = c_S2_ZERO;
                        w_rdsrc = c_RD_CSR;
                        w_wcsr  = 1'b1;
                    end
                    3'b010: begin
                        w_itype = c_IT_I;
                        w_aluop = c_ALU_OR;
                        w_src2  = c_S2_CSR;
                        w_rdsrc = c_RD_CSR;
                        w_wcsr  = 1'b1;
                    end
                    default: w_ill = 1'b1;
                endcase
            end
            default: w_ill = 1'b1;
        endcase

        // An illegal word must have no side effects downstream.
        if (w_ill) begin
            w_rdsrc  = c_RD_NONE;
            w_mvalid = 1'b0;
            w_mwen   = 1'b0;
            w_mwmask = 8'h00;
            w_branch = 1'b0;
            w_jump   = 1'b0;
            w_jalr   = 1'b0;
            w_wcsr   = 1'b0;
            w_ecall  = 1'b0;
            w_mret   = 1'b0;
            w_ebreak = 1'b0;
            w_itype  = c_IT_N;
        end
    end

    // Immediate assembled as 32 bits, then sign-extended to XLEN.
    logic [31:0]     w_imm32;
    logic [XLEN-1:0] w_imm;

    always_comb begin
        case (w_itype)
            c_IT_I:  w_imm32 = {{20{in_inst[31]}}, in_inst[31:20]};
            c_IT_S:  w_imm32 = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
            c_IT_B:  w_imm32 = {{19{in_inst[31]}}, in_inst[31], in_inst[7],
                                in_inst[30:25], in_inst[11:8], 1'b0};
            c_IT_U:  w_imm32 = {in_inst[31:12], 12'b0};
            c_IT_J:  w_imm32 = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12],
                                in_inst[20], in_inst[30:21], 1'b0};
            default: w_imm32 = 32'b0;
        endcase
        w_imm       = {XLEN{w_imm32[31]}};
        w_imm[31:0] = w_imm32;
    end

    logic [37:0]     w_ctrl;
    logic [c_EW-1:0] w_entry;

    assign w_ctrl  = {w_mvalid, w_mwen, w_mwmask, w_mrtype, w_cmp, w_branch,
                      w_jump, w_jalr, w_aluop, w_rdsrc, w_src1, w_src2,
                      w_itype, w_ecall, w_mret, w_wcsr, w_ebreak, w_ill};
    assign w_entry = {in_pc, in_inst[11:7], in_inst[19:15], in_inst[24:20],
                      w_imm, w_ctrl};

    // ------------------------------------------------------------------------
    // Queue
    // ------------------------------------------------------------------------
    logic [c_EW-1:0] r_mem [QDEPTH];
    logic [c_PW-1:0] r_wr_ptr, r_rd_ptr;
    logic [c_CW-1:0] r_count;
    logic [c_EW-1:0] r_last;
    logic [c_EW-1:0] w_head;
    logic            w_push, w_pop;

    assign out_valid = (r_count != '0);
    assign in_ready  = (r_count < c_FULL) | out_ready;
    assign w_push    = in_valid & in_ready & ~flush;
    assign w_pop     = out_valid & out_ready & ~flush;
    assign out_count = r_count;

    // When empty the head pointer may sit on a stale slot, so the outputs
    // fall back to whatever was last presented.
    assign w_head = out_valid ? r_mem[r_rd_ptr] : r_last;

    assign {out_pc, out_rd, out_rs1, out_rs2, out_imm, out_ctrl} = w_head;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_last   <= '0;
        end else begin
            r_last <= w_head;
            if (flush) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_count  <= '0;
            end else begin
                if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
                if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
                if (w_push && !w_pop)      r_count <= r_count + 1'b1;
                else if (w_pop && !w_push) r_count <= r_count - 1'b1;
            end
        end
    end

    // Payload storage carries no reset.
    always_ff @(posedge clk) begin
        if (w_push && !rst) r_mem[r_wr_ptr] <= w_entry;
    end

endmodule
`default_nettype wire

// File: tb/tb_idu_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_idu_pipe
// Purpose  : Directed self-checking bench for idu_pipe. Two instances share
//            the stimulus: one with the M extension enabled, one without.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_idu_pipe;

    // out_ctrl field map (bit positions):
    // mvalid 37, mwen 36, mwmask 35:28, mrtype 27:25, cmp 24:22, branch 21,
    // jump 20, jalr 19, aluop 18:15, rdsrc 14:12, src1 11:10, src2 9:8,
    // itype 7:5, ecall 4, mret 3, wcsr 2, ebreak 1, illegal 0

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, out_ready;
    logic [31:0] in_inst, in_pc;

    logic        in_ready, out_valid;
    logic [31:0] out_pc, out_imm;
    logic [4:0]  out_rd, out_rs1, out_rs2;
    logic [37:0] out_ctrl;
    logic [1:0]  out_count;

    logic        m0_in_ready, m0_out_valid;
    logic [31:0] m0_out_pc, m0_out_imm;
    logic [4:0]  m0_out_rd, m0_out_rs1, m0_out_rs2;
    logic [37:0] m0_out_ctrl;
    logic [1:0]  m0_out_count;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    idu_pipe #(.XLEN(32), .QDEPTH(2), .EN_M(1)) u_dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_inst(in_inst), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2),
        .out_imm(out_imm), .out_ctrl(out_ctrl), .out_count(out_count)
    );

    idu_pipe #(.XLEN(32), .QDEPTH(2), .EN_M(0)) u_dut_nom (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(m0_in_ready),
        .in_inst(in_inst), .in_pc(in_pc),
        .out_valid(m0_out_valid), .out_ready(out_ready),
        .out_pc(m0_out_pc), .out_rd(m0_out_rd), .out_rs1(m0_out_rs1), .out_rs2(m0_out_rs2),
        .out_imm(m0_out_imm), .out_ctrl(m0_out_ctrl), .out_count(m0_out_count)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_inst = 32'h0; in_pc = 32'h0;
        tick(); tick();
        rst = 1'b0;
        n_total++; if (out_valid !== 1'b0) $display("FAIL reset_valid got %0h want 0", out_valid); else n_pass++;
        n_total++; if (out_count !== 2'd0) $display("FAIL reset_count got %0d want 0", out_count); else n_pass++;
        n_total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %0h want 1", in_ready); else n_pass++;
    endtask

    task automatic test_addi();
        in_valid = 1'b1; in_inst = 32'hFFF0_0093; in_pc = 32'h8000_0000;
        tick();
        in_valid = 1'b0;
        n_total++; if (out_valid !== 1'b1) $display("FAIL addi_valid got %0h want 1", out_valid); else n_pass++;
        n_total++; if (out_pc !== 32'h8000_0000) $display("FAIL addi_pc got %0h want 80000000", out_pc); else n_pass++;
        n_total++; if (out_rd !== 5'd1) $display("FAIL addi_rd got %0d want 1", out_rd); else n_pass++;
        n_total++; if (out_rs1 !== 5'd0) $display("FAIL addi_rs1 got %0d want 0", out_rs1); else n_pass++;
        n_total++; if (out_imm !== 32'hFFFF_FFFF) $display("FAIL addi_imm got %0h want ffffffff", out_imm); else n_pass++;
        n_total++; if (out_ctrl[18:15] !== 4'd0) $display("FAIL addi_aluop got %0d want 0", out_ctrl[18:15]); else n_pass++;
        n_total++; if (out_ctrl[7:5] !== 3'd0) $display("FAIL addi_itype got %0d want 0", out_ctrl[7:5]); else n_pass++;
        n_total++; if (out_ctrl[9:8] !== 2'd1) $display("FAIL addi_src2 got %0d want 1", out_ctrl[9:8]); else n_pass++;
        n_total++; if (out_ctrl[14:12] !== 3'd0) $display("FAIL addi_rdsrc got %0d want 0", out_ctrl[14:12]); else n_pass++;
        n_total++; if (out_ctrl[0] !== 1'b0) $display("FAIL addi_illegal got %0h want 0", out_ctrl[0]); else n_pass++;
        n_total++; if (out_count !== 2'd1) $display("FAIL addi_count got %0d want 1", out_count); else n_pass++;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        n_total++; if (out_valid !== 1'b0) $display("FAIL addi_pop_valid got %0h want 0", out_valid); else n_pass++;
        n_total++; if (out_pc !== 32'h8000_0000) $display("FAIL addi_hold_pc got %0h want 80000000", out_pc); else n_pass++;
    endtask

    task automatic test_full_wrap();
        // Pointers start at 1 here, so the three pushes use slots 1,0,1.
        in_valid = 1'b1; in_inst = 32'h0050_0113; in_pc = 32'h0000_0100;
        tick();
        in_inst = 32'h0060_0193; in_pc = 32'h0000_0104;
        tick();
        in_valid = 1'b0;
        n_total++; if (out_count !== 2'd2) $display("FAIL full_count got %0d want 2", out_count); else n_pass++;
        n_total++; if (in_ready !== 1'b0) $display("FAIL full_in_ready got %0h want 0", in_ready); else n_pass++;
        n_total++; if (out_pc !== 32'h100) $display("FAIL full_head_pc got %0h want 100", out_pc); else n_pass++;
        out_ready = 1'b1; in_valid = 1'b1; in_inst = 32'h0070_0213; in_pc = 32'h0000_0108;
        #1;
        n_total++; if (in_ready !== 1'b1) $display("FAIL full_pass_in_ready got %0h want 1", in_ready); else n_pass++;
        tick();
        in_valid = 1'b0;
        n_total++; if (out_count !== 2'd2) $display("FAIL pushpop_count got %0d want 2", out_count); else n_pass++;
        n_total++; if (out_pc !== 32'h104) $display("FAIL pushpop_pc got %0h want 104", out_pc); else n_pass++;
        n_total++; if (out_rd !== 5'd3) $display("FAIL pushpop_rd got %0d want 3", out_rd); else n_pass++;
        tick();
        n_total++; if (out_pc !== 32'h108) $display("FAIL wrap_pc got %0h want 108", out_pc); else n_pass++;
        n_total++; if (out_imm !== 32'd7) $display("FAIL wrap_imm got %0h want 7", out_imm); else n_pass++;
        n_total++; if (out_count !== 2'd1) $display("FAIL wrap_count got %0d want 1", out_count); else n_pass++;
        tick();
        out_ready = 1'b0;
        n_total++; if (out_valid !== 1'b0) $display("FAIL drain_valid got %0h want 0", out_valid); else n_pass++;
    endtask

    task automatic test_mul();
        in_valid = 1'b1; in_inst = 32'h0220_8033; in_pc = 32'h0000_0200;
        tick();
        in_valid = 1'b0;
        n_total++; if (out_ctrl[18:15] !== 4'd8) $display("FAIL mul_aluop got %0d want 8", out_ctrl[18:15]); else n_pass++;
        n_total++; if (out_ctrl[0] !== 1'b0) $display("FAIL mul_illegal got %0h want 0", out_ctrl[0]); else n_pass++;
        n_total++; if (out_ctrl[7:5] !== 3'd2) $display("FAIL mul_itype got %0d want 2", out_ctrl[7:5]); else n_pass++;
        n_total++; if (m0_out_valid !== 1'b1) $display("FAIL nom_valid got %0h want 1", m0_out_valid); else n_pass++;
        n_total++; if (m0_out_ctrl[0] !== 1'b1) $display("FAIL nom_illegal got %0h want 1", m0_out_ctrl[0]); else n_pass++;
        n_total++; if (m0_out_ctrl[14:12] !== 3'd5) $display("FAIL nom_rdsrc got %0d want 5", m0_out_ctrl[14:12]); else n_pass++;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_branch_store();
        in_valid = 1'b1; in_inst = 32'h0000_0463; in_pc = 32'h0000_0300;
        tick();
        in_inst = 32'h0011_2223; in_pc = 32'h0000_0304;
        tick();
        in_valid = 1'b0;
        n_total++; if (out_ctrl[21] !== 1'b1) $display("FAIL beq_branch got %0h want 1", out_ctrl[21]); else n_pass++;
        n_total++; if (out_ctrl[24:22] !== 3'd0) $display("FAIL beq_cmp got %0d want 0", out_ctrl[24:22]); else n_pass++;
        n_total++; if (out_ctrl[18:15] !== 4'd1) $display("FAIL beq_aluop got %0d want 1", out_ctrl[18:15]); else n_pass++;
        n_total++; if (out_imm !== 32'd8) $display("FAIL beq_imm got %0h want 8", out_imm); else n_pass++;
        n_total++; if (out_ctrl[14:12] !== 3'd5) $display("FAIL beq_rdsrc got %0d want 5", out_ctrl[14:12]); else n_pass++;
        n_total++; if (out_ctrl[7:5] !== 3'd5) $display("FAIL beq_itype got %0d want 5", out_ctrl[7:5]); else n_pass++;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        n_total++; if (out_pc !== 32'h304) $display("FAIL sw_pc got %0h want 304", out_pc); else n_pass++;
        n_total++; if (out_ctrl[37:36] !== 2'b11) $display("FAIL sw_mvalid_mwen got %0h want 3", out_ctrl[37:36]); else n_pass++;
        n_total++; if (out_ctrl[35:28] !== 8'h0F) $display("FAIL sw_mwmask got %0h want 0f", out_ctrl[35:28]); else n_pass++;
        n_total++; if (out_ctrl[27:25] !== 3'd2) $display("FAIL sw_mrtype got %0d want 2", out_ctrl[27:25]); else n_pass++;
        n_total++; if (out_imm !== 32'd4) $display("FAIL sw_imm got %0h want 4", out_imm); else n_pass++;
        n_total++; if (out_ctrl[7:5] !== 3'd1) $display("FAIL sw_itype got %0d want 1", out_ctrl[7:5]); else n_pass++;
        n_total++; if (out_ctrl[21] !== 1'b0) $display("FAIL sw_branch got %0h want 0", out_ctrl[21]); else n_pass++;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_flush();
        in_valid = 1'b1; in_inst = 32'h0050_0113; in_pc = 32'h0000_0400;
        tick();
        in_pc = 32'h0000_0404;
        tick();
        n_total++; if (out_count !== 2'd2) $display("FAIL preflush_count got %0d want 2", out_count); else n_pass++;
        flush = 1'b1; out_ready = 1'b1; in_pc = 32'h0000_0408;
        tick();
        flush = 1'b0; out_ready = 1'b0; in_valid = 1'b0;
        n_total++; if (out_valid !== 1'b0) $display("FAIL flush_valid got %0h want 0", out_valid); else n_pass++;
        n_total++; if (out_count !== 2'd0) $display("FAIL flush_count got %0d want 0", out_count); else n_pass++;
        tick();
        n_total++; if (out_count !== 2'd0) $display("FAIL flush_drop_input got %0d want 0", out_count); else n_pass++;
    endtask

    task automatic test_illegal_ebreak();
        in_valid = 1'b1; in_inst = 32'hFFFF_FFFF; in_pc = 32'h0000_0500;
        tick();
        in_inst = 32'h0010_0073; in_pc = 32'h0000_0504;
        tick();
        in_valid = 1'b0;
        n_total++; if (out_ctrl[0] !== 1'b1) $display("FAIL ill_illegal got %0h want 1", out_ctrl[0]); else n_pass++;
        n_total++; if (out_ctrl[14:12] !== 3'd5) $display("FAIL ill_rdsrc got %0d want 5", out_ctrl[14:12]); else n_pass++;
        n_total++; if (out_ctrl[37] !== 1'b0) $display("FAIL ill_mvalid got %0h want 0", out_ctrl[37]); else n_pass++;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        n_total++; if (out_ctrl[1] !== 1'b1) $display("FAIL ebreak_flag got %0h want 1", out_ctrl[1]); else n_pass++;
        n_total++; if (out_ctrl[0] !== 1'b0) $display("FAIL ebreak_illegal got %0h want 0", out_ctrl[0]); else n_pass++;
        n_total++; if (out_ctrl[14:12] !== 3'd5) $display("FAIL ebreak_rdsrc got %0d want 5", out_ctrl[14:12]); else n_pass++;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_total++; if (out_valid !== 1'b0) $display("FAIL rst_valid got %0h want 0", out_valid); else n_pass++;
        n_total++; if (out_count !== 2'd0) $display("FAIL rst_count got %0d want 0", out_count); else n_pass++;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired got timeout want finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_addi();
        test_full_wrap();
        test_mul();
        test_branch_store();
        test_flush();
        test_illegal_ebreak();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
